// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   state_t        transmitter FSM states
//   OVERSAMPLE     ticks per data/start bit
//   clog2()        ceiling log2, used for counter and level widths
//   tick_div()     clk cycles per oversampling tick, integer division
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int OVERSAMPLE = 16;

    // Smallest w such that 2**w >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int tick_div(input int clock_freq, input int baud);
        return clock_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_fifo_tx_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered full/empty/level.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write request; ignored while full
//   pop          read request; ignored while empty
//   wr_data      data written on an accepted push
//   rd_data      head entry (combinational, valid while !empty)
//   full/empty   registered occupancy flags
//   level        registered occupancy, 0..DEPTH
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // Gating with the registered flags means a write while full is dropped
    // even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = level;
        if (do_push && !do_pop) begin
            count_next = level + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= count_next;
            full  <= (count_next == LW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: buffered 8N1 UART transmitter with private 16x tick generator.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        write strobe, pushes wr_data when not full
//   wr_data      byte to transmit
//   full/empty   FIFO occupancy flags, level = current occupancy
//   overflow     one-cycle pulse after a write attempted while full
//   tx           serial line, idle high, LSB first
//   busy         FSM is not in IDLE
//   tx_done      one-cycle pulse in the last cycle of each stop bit
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DBIT-1:0]             wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(FIFO_DEPTH):0]  level,
    output logic                        overflow,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done
);

    localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD);
    localparam int TW       = clog2(TICK_DIV);
    localparam int SMAX     = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int SW       = clog2(SMAX);
    localparam int NW       = (DBIT > 1) ? clog2(DBIT) : 1;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("uart_fifo_tx: CLOCK_FREQ/(BAUD*16) must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   tick_cnt;
    logic            s_tick;
    logic [SW-1:0]   s_cnt;
    logic [SW-1:0]   s_cnt_next;
    logic [NW-1:0]   n_cnt;
    logic [NW-1:0]   n_cnt_next;
    logic [DBIT-1:0] shreg;
    logic [DBIT-1:0] shreg_next;
    logic            tx_next;
    logic            fifo_pop;
    logic [DBIT-1:0] fifo_data;

    uart_sync_fifo #(
        .WIDTH (DBIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Held at zero in IDLE so every frame starts on a fresh tick phase and
    // each bit lasts exactly OVERSAMPLE*TICK_DIV cycles.
    assign s_tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (state == IDLE || s_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_cnt_next = n_cnt;
        shreg_next = shreg;
        tx_next    = 1'b1;
        fifo_pop   = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    fifo_pop   = 1'b1;
                    shreg_next = fifo_data;
                    s_cnt_next = '0;
                    n_cnt_next = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_next = '0;
                        n_cnt_next = '0;
                        state_next = DATA;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = shreg[0];
                if (s_tick) begin
                    if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_next = '0;
                        shreg_next = shreg >> 1;
                        if (n_cnt == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        tx_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx is registered from the current state, so the line trails the FSM
    // by one cycle; reset still forces it high asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            s_cnt    <= s_cnt_next;
            n_cnt    <= n_cnt_next;
            tx       <= tx_next;
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_next;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Testbench for uart_fifo_tx: three instances (fast link, 2-stop-bit link,
// default parameters) with a scoreboard decoding the fast link's line.
module tb_uart_fifo_tx;

    localparam int BIT_CYC = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en_a = 1'b0, wr_en_b = 1'b0, wr_en_c = 1'b0;
    logic [7:0] wr_data_a = '0, wr_data_b = '0, wr_data_c = '0;
    logic       full_a, empty_a, ovf_a, tx_a, busy_a, done_a;
    logic       full_b, empty_b, ovf_b, tx_b, busy_b, done_b;
    logic       full_c, empty_c, ovf_c, tx_c, busy_c, done_c;
    logic [4:0] level_a, level_b, level_c;

    uart_fifo_tx #(.CLOCK_FREQ(1_600_000), .BAUD(10_000), .DBIT(8), .SB_TICK(16), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a), .empty(empty_a),
        .level(level_a), .overflow(ovf_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a));

    uart_fifo_tx #(.CLOCK_FREQ(1_600_000), .BAUD(10_000), .DBIT(8), .SB_TICK(32), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b), .empty(empty_b),
        .level(level_b), .overflow(ovf_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b));

    uart_fifo_tx dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_data(wr_data_c), .full(full_c), .empty(empty_c),
        .level(level_c), .overflow(ovf_c), .tx(tx_c), .busy(busy_c), .tx_done(done_c));

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b1;
    int         done_cnt_a = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] b, input bit keep);
        wr_en_a   = 1'b1;
        wr_data_a = b;
        @(negedge clk);
        wr_en_a = 1'b0;
        if (keep) exp_q.push_back(b);
    endtask

    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

    // Line decoder for dut_a: mid-bit sampling, compared against the queue.
    initial begin : monitor_a
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_a === 1'b0) begin
                repeat (BIT_CYC / 2 - 1) @(negedge clk);
                chk("rx_start", tx_a, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    rx[i] = tx_a;
                end
                repeat (BIT_CYC) @(negedge clk);
                chk("rx_stop", tx_a, 1);
                if (exp_q.size() == 0) chk("rx_unexpected", {24'h0, rx}, 32'h100);
                else chk("rx_byte", {24'h0, rx}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    int         done0, waited, limit, wave_err, busy_err, done_err;
    int         peak, first_hi, hi_run, d1, d2, done_k, busy_fall, run_cnt;
    bit         seen_low;
    int         done_t[$];
    logic [9:0] pattern;

    initial begin : main
        // Reset state, checked while rst_n is held low
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_level", level_a, 0);
        chk("rst_b", {ovf_b, full_b, empty_b, level_b, tx_b, busy_b}, 10'b0010_0000_10);
        chk("rst_c", {ovf_c, full_c, empty_c, level_c, tx_c, busy_c, done_c}, 11'b0010_0000_100);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte 0xA5: exact waveform, busy window and tx_done position
        done0 = done_cnt_a;
        push_a(8'hA5, 1);
        chk("single_lvl_n1", level_a, 1);
        chk("single_busy_n1", busy_a, 0);
        chk("single_tx_n1", tx_a, 1);
        @(negedge clk);
        chk("single_lvl_n2", level_a, 0);
        chk("single_busy_n2", busy_a, 1);
        chk("single_tx_n2", tx_a, 1);
        pattern = {1'b1, 8'hA5, 1'b0};
        wave_err = 0; busy_err = 0; done_err = 0;
        for (int k = 0; k < 1620; k++) begin
            @(negedge clk);
            if (tx_a !== ((k >= 1600) ? 1'b1 : pattern[k / BIT_CYC])) wave_err++;
            if (busy_a !== (k < 1599)) busy_err++;
            if (done_a !== (k == 1598)) done_err++;
        end
        chk("single_wave", wave_err, 0);
        chk("single_busy", busy_err, 0);
        chk("single_done_pos", done_err, 0);
        chk("single_done_cnt", done_cnt_a - done0, 1);
        chk("single_empty", empty_a, 1);

        // Burst of three bytes on consecutive cycles
        done0 = done_cnt_a;
        done_t.delete();
        push_a(8'h00, 1);
        push_a(8'hFF, 1);
        push_a(8'h55, 1);
        peak = int'(level_a);
        first_hi = -1; hi_run = 0; seen_low = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (int'(level_a) > peak) peak = int'(level_a);
            if (done_a === 1'b1) done_t.push_back(k);
            if (tx_a === 1'b0) begin
                if (hi_run > 0 && first_hi < 0) first_hi = hi_run;
                seen_low = 1'b1;
                hi_run = 0;
            end else if (seen_low) begin
                hi_run++;
            end
        end
        d1 = -1; d2 = -1;
        if (done_t.size() == 3) begin
            d1 = done_t[1] - done_t[0];
            d2 = done_t[2] - done_t[1];
        end
        chk("burst_done_cnt", done_cnt_a - done0, 3);
        chk("burst_period1", d1, 1601);
        chk("burst_period2", d2, 1601);
        chk("burst_gap_high", first_hi, 161);
        chk("burst_peak_ok", (peak >= 2 && peak <= 3), 1);
        chk("burst_level_end", level_a, 0);

        // Overflow: fill while a frame is on the line
        done0 = done_cnt_a;
        push_a(8'h10, 1);
        repeat (20) @(negedge clk);
        chk("ovf_line_busy", busy_a, 1);
        chk("ovf_lvl0", level_a, 0);
        for (int i = 0; i < 17; i++) begin
            push_a(8'(32'h20 + i), i < 16);
            if (i == 14) chk("ovf_full15", full_a, 0);
            if (i == 15) begin
                chk("ovf_full16", full_a, 1);
                chk("ovf_lvl16", level_a, 16);
                chk("ovf_no_pulse", ovf_a, 0);
            end
            if (i == 16) begin
                chk("ovf_pulse", ovf_a, 1);
                chk("ovf_lvl_hold", level_a, 16);
            end
        end
        @(negedge clk);
        chk("ovf_pulse_end", ovf_a, 0);
        limit = 17 * 1601 + 2000;
        waited = 0;
        while (!(empty_a === 1'b1 && busy_a === 1'b0) && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk("ovf_drain_in_time", waited < limit, 1);
        repeat (100) @(negedge clk);
        chk("ovf_queue_left", exp_q.size(), 0);
        chk("ovf_done_cnt", done_cnt_a - done0, 17);

        // Reset in the third bit period of 0x3C (d1, line low), with a byte buffered
        mon_en = 1'b0;
        push_a(8'h3C, 0);
        waited = 0;
        while (tx_a !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("rmid_start_seen", tx_a, 0);
        push_a(8'h77, 0);
        repeat (398) @(negedge clk);
        chk("rmid_pre_tx", tx_a, 0);
        chk("rmid_pre_lvl", level_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_tx", tx_a, 1);
        chk("rmid_lvl", level_a, 0);
        chk("rmid_empty", empty_a, 1);
        chk("rmid_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done0 = done_cnt_a;
        run_cnt = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) run_cnt++;
        end
        chk("rmid_quiet", run_cnt, 0);
        chk("rmid_no_done", done_cnt_a - done0, 0);
        mon_en = 1'b1;

        // Two stop bits (SB_TICK=32): 0x81, stop spans 320 cycles
        wr_en_b = 1'b1;
        wr_data_b = 8'h81;
        @(negedge clk);
        wr_en_b = 1'b0;
        waited = 0;
        while (tx_b !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("sb32_start_seen", tx_b, 0);
        pattern = {1'b1, 8'h81, 1'b0};
        wave_err = 0; done_k = -1; busy_fall = -1;
        for (int k = 0; k < 1800; k++) begin
            if (k < 1440 && (k % BIT_CYC) == 80 && tx_b !== pattern[k / BIT_CYC]) wave_err++;
            if (k >= 1440 && tx_b !== 1'b1) wave_err++;
            if (done_b === 1'b1) done_k = k;
            if (busy_b === 1'b0 && busy_fall < 0) busy_fall = k;
            @(negedge clk);
        end
        chk("sb32_wave", wave_err, 0);
        chk("sb32_done_pos", done_k, 1758);
        chk("sb32_idle_pos", busy_fall, 1759);

        // Default parameters: 0x41, start bit and bit0 each 5200 cycles
        wr_en_c = 1'b1;
        wr_data_c = 8'h41;
        @(negedge clk);
        wr_en_c = 1'b0;
        waited = 0;
        while (tx_c !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("def_start_seen", tx_c, 0);
        run_cnt = 0;
        while (tx_c === 1'b0 && run_cnt < 6000) begin
            @(negedge clk);
            run_cnt++;
        end
        chk("def_start_len", run_cnt, 5200);
        run_cnt = 0;
        while (tx_c === 1'b1 && run_cnt < 6000) begin
            @(negedge clk);
            run_cnt++;
        end
        chk("def_bit0_len", run_cnt, 5200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
